// File: rtl/lfsr_seq_arb_if.sv
// ---------------------------------------------------------------------------
// lfsr_seq_arb_if
// User-side request/grant/result bundle for lfsr_seq_arb.
//
// Parameters:
//   LFSR_W  width of the returned LFSR value
//   STEP_W  width of the per-requester step counts
//
// Signals:
//   req[1:0]      per-requester level request (bit i = requester i)
//   mode0/mode1   3-bit mod select for requester 0/1
//   steps0/steps1 advance count for requester 0/1
//   gnt[1:0]      one-hot grant, single-cycle pulse
//   busy          a job is in flight
//   done          single-cycle pulse, result valid
//   done_id       requester that owns result (valid with done)
//   result        LFSR value after the requested advances
//
// Modports:
//   master  user logic (drives requests, observes grant/result)
//   slave   the arbiter/sequencer
// ---------------------------------------------------------------------------
interface lfsr_seq_arb_if #(
  parameter int LFSR_W = 4,
  parameter int STEP_W = 4
);
  logic [1:0]        req;
  logic [2:0]        mode0;
  logic [2:0]        mode1;
  logic [STEP_W-1:0] steps0;
  logic [STEP_W-1:0] steps1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic              done_id;
  logic [LFSR_W-1:0] result;

  modport master (
    output req, mode0, mode1, steps0, steps1,
    input  gnt, busy, done, done_id, result
  );

  modport slave (
    input  req, mode0, mode1, steps0, steps1,
    output gnt, busy, done, done_id, result
  );
endinterface

// File: rtl/lfsr_seq_arb.sv
// ---------------------------------------------------------------------------
// lfsr_seq_arb
// Round-robin arbiter + sequencer sharing one lfsr4 datapath between two
// requesters. A granted job seeds the datapath, lets it advance for the
// requested number of clocks, captures the value and returns it with a
// one-cycle done pulse.
//
// Parameters:
//   LFSR_W  width of lfsr value / result (default 4)
//   STEP_W  width of step counts (default 4)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         lfsr_seq_arb_if.slave: req/mode/steps in, gnt/busy/done/
//               done_id/result out
//   o_lfsr_rst  synchronous seed load to the datapath (active high)
//   o_lfsr_mod  mod select to the datapath
//   i_lfsr_q    current datapath value
//   o_stuck     (only with LFSR_SEQ_STUCK_DET_EN) all-zero lock-up seen
//               during the current job; cleared on the next grant
//
// Optional build macro: LFSR_SEQ_STUCK_DET_EN
//
// Job timeline (E = arbitration edge):
//   E          IDLE -> SEED, gnt pulse, mode/steps latched
//   E+1        datapath loads its seed, SEED -> RUN (or CAPT if steps==0)
//   E+1+steps  RUN -> CAPT (datapath has advanced 'steps' times)
//   E+2+steps  result/done registered, back to IDLE
// ---------------------------------------------------------------------------
module lfsr_seq_arb #(
  parameter int LFSR_W = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  lfsr_seq_arb_if.slave     bus,
  output logic              o_lfsr_rst,
  output logic [2:0]        o_lfsr_mod,
  input  logic [LFSR_W-1:0] i_lfsr_q
`ifdef LFSR_SEQ_STUCK_DET_EN
  ,
  output logic              o_stuck
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    CAPT = 2'd3
  } state_e;

  state_e            r_state,    w_state_nxt;
  logic [1:0]        r_gnt,      w_gnt_nxt;
  logic              r_busy,     w_busy_nxt;
  logic              r_done,     w_done_nxt;
  logic              r_done_id,  w_done_id_nxt;
  logic [LFSR_W-1:0] r_result,   w_result_nxt;
  logic              r_lfsr_rst, w_lfsr_rst_nxt;
  logic [2:0]        r_lfsr_mod, w_lfsr_mod_nxt;
  logic [STEP_W-1:0] r_cnt,      w_cnt_nxt;
  logic              r_owner,    w_owner_nxt;
  // Index of the requester served last; a tie goes to the other one.
  logic              r_last,     w_last_nxt;
  logic              w_winner;
  logic              w_grant;

  // Tie-break toward the requester not served last; otherwise the sole
  // requester wins.
  assign w_winner = (bus.req == 2'b11) ? ~r_last : bus.req[1];
  assign w_grant  = (r_state == IDLE) && (bus.req != 2'b00);

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = 2'b00;
    w_done_nxt     = 1'b0;
    w_done_id_nxt  = r_done_id;
    w_result_nxt   = r_result;
    w_lfsr_rst_nxt = r_lfsr_rst;
    w_lfsr_mod_nxt = r_lfsr_mod;
    w_cnt_nxt      = r_cnt;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;

    case (r_state)
      IDLE: begin
        w_lfsr_rst_nxt = 1'b1;
        if (w_grant) begin
          w_owner_nxt    = w_winner;
          w_lfsr_mod_nxt = w_winner ? bus.mode1  : bus.mode0;
          w_cnt_nxt      = w_winner ? bus.steps1 : bus.steps0;
          w_gnt_nxt      = w_winner ? 2'b10 : 2'b01;
          w_state_nxt    = SEED;
        end
      end
      SEED: begin
        // The edge leaving SEED is the one that loads the seed, so the
        // datapath starts advancing from the following edge.
        w_lfsr_rst_nxt = 1'b0;
        w_state_nxt    = (r_cnt != '0) ? RUN : CAPT;
      end
      RUN: begin
        w_lfsr_rst_nxt = 1'b0;
        w_cnt_nxt      = r_cnt - STEP_W'(1);
        if (r_cnt == STEP_W'(1)) w_state_nxt = CAPT;
      end
      CAPT: begin
        // lfsr_q has advanced exactly 'steps' times here; the datapath
        // steps once more on this edge, which is harmless since it is
        // reseeded before the next job.
        w_result_nxt   = i_lfsr_q;
        w_done_nxt     = 1'b1;
        w_done_id_nxt  = r_owner;
        w_last_nxt     = r_owner;
        w_lfsr_rst_nxt = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gnt      <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_result   <= '0;
      r_lfsr_rst <= 1'b1;
      r_lfsr_mod <= 3'd0;
      r_cnt      <= '0;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;  // favours requester 0 on the first tie
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_done_id  <= w_done_id_nxt;
      r_result   <= w_result_nxt;
      r_lfsr_rst <= w_lfsr_rst_nxt;
      r_lfsr_mod <= w_lfsr_mod_nxt;
      r_cnt      <= w_cnt_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;
  assign bus.result  = r_result;
  assign o_lfsr_rst  = r_lfsr_rst;
  assign o_lfsr_mod  = r_lfsr_mod;

`ifdef LFSR_SEQ_STUCK_DET_EN
  // All-zero lock-up flag: sticky for the rest of the job, cleared when
  // the next job is granted (grant wins over a simultaneous set).
  logic r_stuck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stuck <= 1'b0;
    end else if (w_grant) begin
      r_stuck <= 1'b0;
    end else if (((r_state == RUN) || (r_state == CAPT)) && (i_lfsr_q == '0)) begin
      r_stuck <= 1'b1;
    end
  end

  assign o_stuck = r_stuck;
`endif

endmodule

// File: tb/tb_lfsr_seq_arb.sv
// ---------------------------------------------------------------------------
// tb_lfsr_seq_arb
// Directed bench for lfsr_seq_arb. A small behavioural datapath stands in
// for lfsr4: it loads SEED on an edge with lfsr_rst=1 and otherwise steps
//   q <= {q[2:0], q[3] ^ (m[0] ? q[2] : q[0]) ^ (m[2] & q[1])}
// Expected results below are hand-stepped from seed 4'b0001.
// Inputs change on the falling edge, outputs are sampled on the falling
// edge. "k" counts rising edges after the arbitration edge E; done is set
// by edge E+steps+2 and is therefore high in the cycle ending at E+steps+3.
// ---------------------------------------------------------------------------
module tb_lfsr_seq_arb;

  localparam int          LFSR_W = 4;
  localparam int          STEP_W = 4;
  localparam logic [3:0]  SEED   = 4'b0001;

  logic              clk;
  logic              rst_n;
  logic              lfsr_rst;
  logic [2:0]        lfsr_mod;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] dp_q;
  logic              force_zero;
`ifdef LFSR_SEQ_STUCK_DET_EN
  logic              stuck;
`endif

  int tests_run;
  int tests_failed;

  lfsr_seq_arb_if #(.LFSR_W(LFSR_W), .STEP_W(STEP_W)) bus ();

  lfsr_seq_arb #(.LFSR_W(LFSR_W), .STEP_W(STEP_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .o_lfsr_rst (lfsr_rst),
    .o_lfsr_mod (lfsr_mod),
    .i_lfsr_q   (lfsr_q)
`ifdef LFSR_SEQ_STUCK_DET_EN
    ,
    .o_stuck    (stuck)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dp_step(input logic [3:0] q, input logic [2:0] m);
    logic fb;
    fb = q[3] ^ (m[0] ? q[2] : q[0]) ^ (m[2] & q[1]);
    return {q[2:0], fb};
  endfunction

  // Stand-in datapath.
  always @(posedge clk) begin
    if (lfsr_rst) dp_q <= SEED;
    else          dp_q <= dp_step(dp_q, lfsr_mod);
  end
  assign lfsr_q = force_zero ? '0 : dp_q;

  // Waits (bounded) for done, starting at the sample point k=0.
  // Returns k of the sample where done was seen (-1 on timeout) and the
  // number of samples k>=1 with lfsr_rst low.
  task automatic wait_done(output int k, output int lo);
    k  = -1;
    lo = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (!lfsr_rst) lo++;
      if (bus.done) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.gnt, bus.done, bus.done_id, bus.busy, lfsr_rst, lfsr_mod} !== {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: gnt=%b done=%b id=%b busy=%b rst=%b mod=%b, want 00 0 0 0 1 000",
               bus.gnt, bus.done, bus.done_id, bus.busy, lfsr_rst, lfsr_mod);
    end
    tests_run++;
    if (bus.result !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want 0", bus.result);
    end
  endtask

  // req=11 held from reset: 0, then 1 on job 0's done cycle, then 0 again.
  task automatic test_contention();
    int k, lo;
    bus.req    = 2'b11;
    bus.mode0  = 3'b000; bus.steps0 = 4'd2;  // 1 -> 3 -> 7
    bus.mode1  = 3'b011; bus.steps1 = 4'd1;  // 1 -> 2
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL tie_first_gnt: got %b want 01", bus.gnt);
    end
    wait_done(k, lo);
    tests_run++;
    if ({k, bus.done_id, bus.result} !== {32'd4, 1'b0, 4'h7}) begin
      tests_failed++;
      $display("FAIL tie_job0: k=%0d id=%b result=%h, want k=4 id=0 result=7", k, bus.done_id, bus.result);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.gnt, bus.busy} !== {2'b10, 1'b1}) begin
      tests_failed++;
      $display("FAIL tie_b2b_gnt1: gnt=%b busy=%b, want 10 1", bus.gnt, bus.busy);
    end
    wait_done(k, lo);
    tests_run++;
    if ({k, bus.done_id, bus.result} !== {32'd3, 1'b1, 4'h2}) begin
      tests_failed++;
      $display("FAIL tie_job1: k=%0d id=%b result=%h, want k=3 id=1 result=2", k, bus.done_id, bus.result);
    end
    @(negedge clk);
    tests_run++;
    if (bus.gnt !== 2'b01) begin
      tests_failed++;
      $display("FAIL tie_rr_back_to_0: got %b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    wait_done(k, lo);
    @(negedge clk);
  endtask

  task automatic test_single();
    int k, lo;
    bus.mode0 = 3'b010; bus.steps0 = 4'd5;  // 1 3 7 F E D
    bus.req   = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    tests_run++;
    if ({bus.gnt, lfsr_mod, lfsr_rst, bus.busy} !== {2'b01, 3'b010, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_grant: gnt=%b mod=%b rst=%b busy=%b, want 01 010 1 1",
               bus.gnt, lfsr_mod, lfsr_rst, bus.busy);
    end
    wait_done(k, lo);
    tests_run++;
    if ({k, lo} !== {32'd7, 32'd6}) begin
      tests_failed++;
      $display("FAIL single_timing: done k=%0d rst_low=%0d, want k=7 rst_low=6", k, lo);
    end
    tests_run++;
    if ({bus.result, bus.done_id} !== {4'hD, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_result: result=%h id=%b, want D 0", bus.result, bus.done_id);
    end
    @(negedge clk);
    tests_run++;
    if ({bus.done, bus.busy, bus.result} !== {1'b0, 1'b0, 4'hD}) begin
      tests_failed++;
      $display("FAIL single_after: done=%b busy=%b result=%h, want 0 0 D", bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_zero_steps();
    int k, lo;
    bus.mode1 = 3'b001; bus.steps1 = 4'd0;
    bus.req   = 2'b10;
    @(negedge clk);
    bus.req = 2'b00;
    tests_run++;
    if ({bus.gnt, lfsr_mod} !== {2'b10, 3'b001}) begin
      tests_failed++;
      $display("FAIL zero_grant: gnt=%b mod=%b, want 10 001", bus.gnt, lfsr_mod);
    end
    wait_done(k, lo);
    tests_run++;
    if ({k, lo, bus.result, bus.done_id} !== {32'd2, 32'd1, SEED, 1'b1}) begin
      tests_failed++;
      $display("FAIL zero_job: k=%0d rst_low=%0d result=%h id=%b, want k=2 rst_low=1 result=1 id=1",
               k, lo, bus.result, bus.done_id);
    end
    @(negedge clk);
  endtask

  task automatic test_sampling();
    int k, lo;
    bus.mode0 = 3'b101; bus.steps0 = 4'd3;  // 1 2 5 B
    bus.req   = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);                          // k=1, in RUN
    bus.steps0 = 4'd9;
    bus.mode0  = 3'b000;
    wait_done(k, lo);
    tests_run++;
    if ({k + 1, lo + 1, bus.result} !== {32'd5, 32'd4, 4'hB}) begin
      tests_failed++;
      $display("FAIL sampling_job: k=%0d rst_low=%0d result=%h, want k=5 rst_low=4 result=B",
               k + 1, lo + 1, bus.result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.mode0 = 3'b010; bus.steps0 = 4'd8;
    bus.req   = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);              // well inside RUN
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.gnt, bus.done, bus.busy, lfsr_rst, lfsr_mod, bus.result} !==
        {2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid: gnt=%b done=%b busy=%b rst=%b mod=%b result=%h, want 00 0 0 1 000 0",
               bus.gnt, bus.done, bus.busy, lfsr_rst, lfsr_mod, bus.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: %0d cycles with done/busy after abort, want 0", seen);
    end
  endtask

`ifdef LFSR_SEQ_STUCK_DET_EN
  task automatic test_stuck();
    int k, lo;
    bus.mode0 = 3'b010; bus.steps0 = 4'd5;
    bus.req   = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    tests_run++;
    if (stuck !== 1'b0) begin
      tests_failed++;
      $display("FAIL stuck_idle: got %b want 0", stuck);
    end
    @(negedge clk);                          // k=1
    @(negedge clk);                          // k=2, RUN
    force_zero = 1'b1;
    @(negedge clk);
    force_zero = 1'b0;
    tests_run++;
    if (stuck !== 1'b1) begin
      tests_failed++;
      $display("FAIL stuck_set: got %b want 1", stuck);
    end
    wait_done(k, lo);
    tests_run++;
    if ({k > 0, stuck} !== 2'b11) begin
      tests_failed++;
      $display("FAIL stuck_through_done: done_seen=%b stuck=%b, want 1 1", k > 0, stuck);
    end
    bus.mode1 = 3'b000; bus.steps1 = 4'd0;
    bus.req   = 2'b10;
    @(negedge clk);
    bus.req = 2'b00;
    tests_run++;
    if ({bus.gnt, stuck} !== {2'b10, 1'b0}) begin
      tests_failed++;
      $display("FAIL stuck_clear: gnt=%b stuck=%b, want 10 0", bus.gnt, stuck);
    end
    wait_done(k, lo);
    @(negedge clk);
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    force_zero   = 1'b0;
    bus.req      = 2'b00;
    bus.mode0    = 3'd0;
    bus.mode1    = 3'd0;
    bus.steps0   = '0;
    bus.steps1   = '0;

    test_reset();
    test_contention();
    test_single();
    test_zero_steps();
    test_sampling();
    test_reset_mid();
`ifdef LFSR_SEQ_STUCK_DET_EN
    test_stuck();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_seq_arb.md
Name: lfsr_seq_arb

Overview:
- Round-robin arbiter and sequencer that shares one lfsr4 datapath between two requesters.
- Each request carries a tap/mode select and a step count.
- The block seeds the LFSR, runs it for the requested number of clocks, then returns the resulting LFSR value with a one-cycle done pulse.
- Sits between user logic and the lfsr4 instance. It owns the instance's reset and mod inputs and reads its lfsr output.

Parameters:
- LFSR_W, 4, width of the LFSR value (lfsr_q, result).
- STEP_W, 4, width of the step-count fields (0..2^STEP_W-1 advances).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, 2, per-requester level request; bit i for requester i.
- mode0, input, 3, mod select for requester 0.
- mode1, input, 3, mod select for requester 1.
- steps0, input, STEP_W, advance count for requester 0.
- steps1, input, STEP_W, advance count for requester 1.
- gnt, output, 2, one-hot grant, one-cycle pulse.
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, one-cycle pulse; result valid.
- done_id, output, 1, requester index that owns result; valid with done.
- result, output, LFSR_W, LFSR value after the requested advances; holds until the next done.
- lfsr_rst, output, 1, active-high synchronous reset/seed load to the datapath.
- lfsr_mod, output, 3, mod select to the datapath.
- lfsr_q, input, LFSR_W, current datapath value. The datapath loads its seed on an edge with lfsr_rst=1 and advances once on every edge with lfsr_rst=0.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, gnt=0, done=0, done_id=0, result=0.
  - lfsr_rst=1, lfsr_mod=0, RR pointer favours requester 0, busy=0.
  - Reset mid-operation aborts the job; no done is produced for it.
- States: IDLE, SEED, RUN, CAPT. All outputs are registered.
- IDLE:
  - lfsr_rst=1.
  - If any req bit is high, pick the winner:
    - Only one bit high: that requester wins.
    - Both bits high: the requester not served last wins; requester 0 wins the first tie after reset.
  - On that edge:
    - latch the winner's mode into lfsr_mod and its steps into the down-counter;
    - store the winner's index;
    - set gnt[winner]=1;
    - go to SEED.
- SEED (1 cycle):
  - gnt pulse visible; lfsr_rst=1; the edge ending SEED loads the seed into the datapath.
  - Next state is RUN if steps != 0, otherwise CAPT.
  - gnt clears and lfsr_rst clears at that edge.
- RUN (exactly steps cycles):
  - lfsr_rst=0; decrement the counter each edge.
  - When the counter reaches 1 on the current cycle, go to CAPT.
- CAPT (1 cycle):
  - lfsr_rst=0; lfsr_q equals seed advanced exactly steps times.
  - Edge ending CAPT: result<=lfsr_q, done<=1, done_id<=owner, update RR pointer, lfsr_rst<=1, go to IDLE.
- done is high for the single IDLE cycle that follows CAPT.
  - Arbitration may occur in that same cycle, giving back-to-back jobs with no gap.
- Latency: req sampled at edge E → gnt during cycle after E → done asserted steps+3 edges after E.
- Requesters must hold req until their gnt and must drop it the cycle gnt is seen. A req still high after gnt is treated as a new request.
- mode/steps are sampled only on the arbitration edge; changes during a job have no effect.
- busy=1 in SEED, RUN and CAPT; 0 in IDLE.

Optional Feature:
- Macro: LFSR_SEQ_STUCK_DET_EN.
- When defined:
  - Adds output stuck (1 bit, reset 0).
  - stuck is set on the edge after lfsr_q==0 is observed during RUN or CAPT (all-zero lock-up).
  - It is sticky until the next grant edge, where it clears.
  - The job still completes normally.
- When undefined: the stuck port and its logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset values: assert rst_n=0 mid-RUN → gnt=0, done=0, result=0, lfsr_rst=1, busy=0 immediately; no done afterwards.
- Single job: req=01, mode0=3'b010, steps0=5 → gnt=01 one cycle; lfsr_mod=010; lfsr_rst low for exactly 6 cycles (5 RUN + CAPT); done at E+8; result equals the seed advanced 5 times per the lfsr4 model; done_id=0.
- Zero steps: req=10, steps1=0 → SEED then CAPT; result=seed value; done at E+3; done_id=1.
- Contention: req=11 held from reset → requester 0 granted first. Requester 1 granted on the done cycle of job 0 (back-to-back, no IDLE gap). With both still requesting, the next grant goes to requester 0.
- Sampling: change steps0 from 3 to 9 during RUN → job still runs 3 advances; done at E+6.
- With LFSR_SEQ_STUCK_DET_EN: force lfsr_q=0 during RUN → stuck=1 on the next edge, stays 1 through done, clears on the next grant.
